// File: rtl/conv3d_group_sequencer.sv
// Feeds a 3-channel conv3d engine over NUM_GROUPS channel groups and tags its outputs for psum accumulation.
// Latency: start -> first rd_en 1 cycle; mem_ready=0 stalls reads without skipping, engine outputs are never stalled.
module conv3d_group_sequencer #(
  parameter int IMG_WIDTH  = 56,
  parameter int IMG_HEIGHT = 56,
  parameter int NUM_GROUPS = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int GRP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  mem_ready,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [GRP_WIDTH-1:0]  rd_group,
  output logic                  eng_valid_in,
  input  logic                  eng_valid_out,
  input  logic                  eng_done,
  output logic                  psum_wr,
  output logic [ADDR_WIDTH-1:0] psum_addr,
  output logic                  psum_first,
  output logic                  psum_last,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [GRP_WIDTH-1:0]  LAST_GRP = GRP_WIDTH'(NUM_GROUPS - 1);

  typedef enum logic [2:0] {IDLE, FEED, DRAIN, NEXT, FINISH} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] in_cnt, in_cnt_nxt;
  logic [ADDR_WIDTH-1:0] out_cnt, out_cnt_nxt;
  logic [GRP_WIDTH-1:0]  group, group_nxt;
  logic                  err_nxt;
  logic                  tracking;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      in_cnt       <= '0;
      out_cnt      <= '0;
      group        <= '0;
      err          <= 1'b0;
      eng_valid_in <= 1'b0;
    end else begin
      state        <= state_nxt;
      in_cnt       <= in_cnt_nxt;
      out_cnt      <= out_cnt_nxt;
      group        <= group_nxt;
      err          <= err_nxt;
      eng_valid_in <= rd_en;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_cnt_nxt  = in_cnt;
    out_cnt_nxt = out_cnt;
    group_nxt   = group;
    err_nxt     = err;
    rd_en       = 1'b0;
    psum_wr     = 1'b0;
    tracking    = (state == FEED) || (state == DRAIN);

    // The engine pipeline can still be emitting while we feed, so outputs count in both states.
    if (tracking && eng_valid_out) begin
      psum_wr     = 1'b1;
      out_cnt_nxt = (out_cnt == LAST_PIX) ? '0 : out_cnt + 1'b1;
    end
    if (tracking && eng_done && (out_cnt != LAST_PIX))
      err_nxt = 1'b1;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = FEED;
          group_nxt   = '0;
          in_cnt_nxt  = '0;
          out_cnt_nxt = '0;
          err_nxt     = 1'b0;
        end
      end
      FEED: begin
        if (mem_ready) begin
          rd_en = 1'b1;
          if (in_cnt == LAST_PIX) begin
            in_cnt_nxt = '0;
            state_nxt  = DRAIN;
          end else begin
            in_cnt_nxt = in_cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (eng_valid_out && (out_cnt == LAST_PIX))
          state_nxt = (group == LAST_GRP) ? FINISH : NEXT;
      end
      NEXT: begin
        group_nxt   = group + 1'b1;
        out_cnt_nxt = '0;
        state_nxt   = FEED;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign done       = (state == FINISH);
  assign rd_addr    = in_cnt;
  assign rd_group   = group;
  assign psum_addr  = out_cnt;
  // Flags are qualified by psum_wr so every output is quiet outside a valid engine pixel.
  assign psum_first = psum_wr && (group == '0);
  assign psum_last  = psum_wr && (group == LAST_GRP);

endmodule
